spi_rd_seq: RTL
===============

# spi_rd_seq

SPI flash read sequencer sitting directly upstream of the `spi_xcvr` byte transceiver. It accepts one read command at a time: opcode, 24-bit address and byte count. It then drives the transceiver's enable/write-request handshake to shift out the opcode, the address bytes and filler bytes, and returns each received data byte on a valid/ready stream. Chip-select framing, inter-byte pacing and output backpressure are all owned here; the transceiver only moves single bytes.

## Interface
- `LEN_W`, 16: width of the data byte count.
- `NSS_GAP`, 4: minimum number of `sys_clk` cycles `xcvr_enable` is held low between commands (≥1).
- `FILL_BYTE`, 8'h00: byte transmitted while clocking in data (and dummy) bytes.
- `sys_clk` in 1: single clock; every register is on its rising edge.
- `sys_rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: high only in IDLE; a command is accepted on `cmd_valid & cmd_ready`.
- `cmd_opcode` in 8: first byte sent.
- `cmd_addr` in 24: address, sent MSB byte first.
- `cmd_len` in LEN_W: number of data bytes to read; 0 is legal.
- `rd_valid` out 1: `rd_data` holds a received byte.
- `rd_ready` in 1: downstream accepts the byte.
- `rd_data` out 8: received data byte.
- `rd_last` out 1: qualifies the final byte of the command.
- `seq_busy` out 1: high from command accept until the GAP state exits.
- `xcvr_enable` out 1: to transceiver `enable`; the transceiver asserts NSS while this is high.
- `xcvr_wr_req` out 1: single-cycle byte request.
- `xcvr_wr_data` out 8: byte to transmit, valid with `xcvr_wr_req`.
- `xcvr_busy` in 1: from the transceiver; monitored only.
- `xcvr_done` in 1: single-cycle pulse at byte completion.
- `xcvr_rd_data` in 8: received byte, valid in the `xcvr_done` cycle.

## Operation
- States: IDLE, OPC, ADDR, DUMMY (compiled in only with the macro in Configuration), DATA, GAP.
- Every byte state has two phases:
  - ISSUE: `xcvr_wr_req`=1 for exactly one cycle.
  - WAIT: hold until `xcvr_done`.
- IDLE:
  - On accept, latch opcode, address and length.
  - Set `xcvr_enable`=1 and go to OPC/ISSUE.
- OPC: on done, go to ADDR with byte index 2.
- ADDR:
  - Send `addr[23:16]`, then `[15:8]`, then `[7:0]`.
  - After the third done, go to DUMMY if the macro is defined.
  - Otherwise go to DATA if len≠0, or to GAP if len=0.
- DATA:
  - Send FILL_BYTE.
  - On done, load `xcvr_rd_data` into `rd_data`, set `rd_valid`=1, and decrement the remaining count.
  - Set `rd_last`=1 when the remaining count reaches 0.
- Backpressure:
  - The next DATA ISSUE is not raised while `rd_valid`=1 and `rd_ready`=0.
  - ISSUE may occur in the same cycle as the `rd_valid & rd_ready` handshake.
- After the last data byte's done, `xcvr_enable` goes to 0 and the state moves to GAP.
  - The final byte may still be pending on the output; GAP does not wait for it.
- GAP:
  - Count NSS_GAP cycles, then return to IDLE.
  - Raise `cmd_ready` only if the output register is empty or being emptied in that cycle.
- Count arithmetic is unsigned LEN_W with no wrap. `cmd_len`=2^LEN_W−1 is legal.
- An `xcvr_done` received outside a WAIT phase is ignored.
- `cmd_valid` while busy has no effect.

## Timing
- Reset values:
  - `cmd_ready`=0 during reset, 1 in the first cycle after reset release.
  - `rd_valid`=0, `rd_data`=0, `rd_last`=0, `seq_busy`=0.
  - `xcvr_enable`=0, `xcvr_wr_req`=0, `xcvr_wr_data`=0.
  - State is IDLE.
- Accept at cycle T: `xcvr_enable`=1 and `xcvr_wr_req`=1 with the opcode, both at T+1.
- A `xcvr_done` at cycle D followed by a non-data byte: next `xcvr_wr_req` at D+1.
- DATA: `rd_valid` rises at D+1. With `rd_ready` held high, the next request is at D+1.
- Last done at D: `xcvr_enable`=0 at D+1, and `cmd_ready` no earlier than D+1+NSS_GAP.
- Asynchronous reset mid-command:
  - Immediately forces IDLE and drops `xcvr_enable`, which aborts the SPI frame.
  - Any pending `rd_valid` is lost.

## Configuration
- `SPI_RD_SEQ_DUMMY_EN` defined: one DUMMY byte (FILL_BYTE, received data discarded) follows the address, for fast-read (0x0B).
- Not defined: no DUMMY state; data follows the address directly.

## Structure
- Package `spi_rd_seq_pkg`:
  - State encoding.
  - Opcode constants `OPC_READ`=8'h03 and `OPC_FAST_READ`=8'h0B.
  - Default fill byte.
  - Address byte count (3).
- One sub-module, `spi_rd_obuf`: a single-entry valid/ready holding register carrying `rd_data` and `rd_last`, with a `full` / `will_empty` status back to the FSM.

## Test plan
- Opcode 0x03, addr 0x123456, len 4; slave returns A0..A3; `rd_ready`=1.
  - MOSI bytes 03,12,34,56,00×4.
  - `rd_data` A0..A3 with `rd_last` on A3.
  - `xcvr_enable` low for ≥NSS_GAP cycles before the next `cmd_ready`.
- len 0: exactly 4 bytes sent, no `rd_valid`, and `seq_busy` falls after the gap.
- Backpressure: len 3 with `rd_ready`=0 for 20 cycles after the first byte.
  - No `xcvr_wr_req` during that window.
  - Data arrives in order with no loss or duplication.
- Macro defined, opcode 0x0B: exactly one 00 dummy byte after the address, and its received byte is never output.
- Reset asserted during ADDR byte 2:
  - `xcvr_enable`=0 and `cmd_ready`=0 while reset is held.
  - `cmd_ready`=1 in the cycle after release.
  - A new command then completes correctly.
- `cmd_valid` held high throughout a command: exactly one accept per IDLE entry, and back-to-back commands are separated by ≥NSS_GAP cycles.

Source files
------------

// File: rtl/spi_rd_seq_pkg.sv
// Shared types and constants for the SPI flash read sequencer.
// The DUMMY state exists only when SPI_RD_SEQ_DUMMY_EN is defined.
package spi_rd_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_OPC,
        ST_ADDR,
`ifdef SPI_RD_SEQ_DUMMY_EN
        ST_DUMMY,
`endif
        ST_DATA,
        ST_GAP
    } state_t;

    typedef enum logic {
        PH_ISSUE,
        PH_WAIT
    } phase_t;

    localparam logic [7:0]  OPC_READ      = 8'h03;
    localparam logic [7:0]  OPC_FAST_READ = 8'h0B;
    localparam logic [7:0]  FILL_DEFAULT  = 8'h00;
    localparam int unsigned ADDR_BYTES    = 3;

endpackage

// File: rtl/spi_rd_obuf.sv
// Single-entry valid/ready holding register for received read bytes.
module spi_rd_obuf (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    input  logic       load_last,
    input  logic       rd_ready,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       rd_last,
    output logic       full,
    output logic       will_empty
);

    assign full       = rd_valid;
    assign will_empty = rd_valid & rd_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_last  <= 1'b0;
        end else if (load) begin
            rd_valid <= 1'b1;
            rd_data  <= load_data;
            rd_last  <= load_last;
        end else if (will_empty) begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/spi_rd_seq.sv
// SPI flash read sequencer driving the spi_xcvr byte handshake.
// Optional fast-read dummy byte: define SPI_RD_SEQ_DUMMY_EN.
module spi_rd_seq
    import spi_rd_seq_pkg::*;
#(
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned NSS_GAP   = 4,
    parameter logic [7:0]  FILL_BYTE = FILL_DEFAULT
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_opcode,
    input  logic [23:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [7:0]       rd_data,
    output logic             rd_last,
    output logic             seq_busy,
    output logic             xcvr_enable,
    output logic             xcvr_wr_req,
    output logic [7:0]       xcvr_wr_data,
    input  logic             xcvr_busy,
    input  logic             xcvr_done,
    input  logic [7:0]       xcvr_rd_data
);

    localparam int unsigned     GAP_W    = (NSS_GAP > 1) ? $clog2(NSS_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(NSS_GAP - 1);

    state_t             state, state_d;
    phase_t             phase, phase_d;
    logic [7:0]         opc_q;
    logic [23:0]        addr_q;
    logic [LEN_W-1:0]   rem_q;
    logic [1:0]         idx_q;
    logic [GAP_W-1:0]   gap_q;
    logic               accept, byte_done, issue_ok, last_data;
    logic               obuf_full, obuf_will_empty, obuf_load, obuf_last;
    logic [7:0]         tx_byte;
    state_t             after_hdr;
    logic               unused_busy;

    assign unused_busy = xcvr_busy;

    assign cmd_ready   = (state == ST_IDLE) && !sys_rst;
    assign accept      = cmd_valid && cmd_ready;
    assign seq_busy    = (state != ST_IDLE);
    assign xcvr_enable = (state != ST_IDLE) && (state != ST_GAP);
    assign byte_done   = xcvr_enable && (phase == PH_WAIT) && xcvr_done;
    assign last_data   = (rem_q == LEN_W'(1));
    assign after_hdr   = (rem_q == '0) ? ST_GAP : ST_DATA;
    // A DATA request may go out in the same cycle the held byte is taken.
    assign issue_ok    = (state != ST_DATA) || !obuf_full || obuf_will_empty;

    always_comb begin
        tx_byte = FILL_BYTE;
        case (state)
            ST_OPC:  tx_byte = opc_q;
            ST_ADDR: begin
                case (idx_q)
                    2'd2:    tx_byte = addr_q[23:16];
                    2'd1:    tx_byte = addr_q[15:8];
                    default: tx_byte = addr_q[7:0];
                endcase
            end
            default: tx_byte = FILL_BYTE;
        endcase
    end

    assign xcvr_wr_data = xcvr_wr_req ? tx_byte : '0;

    always_comb begin
        state_d     = state;
        phase_d     = phase;
        xcvr_wr_req = 1'b0;
        obuf_load   = 1'b0;
        obuf_last   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_OPC;
                    phase_d = PH_ISSUE;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST && (!obuf_full || obuf_will_empty))
                    state_d = ST_IDLE;
            end
            default: begin
                if (phase == PH_ISSUE) begin
                    if (issue_ok) begin
                        xcvr_wr_req = 1'b1;
                        phase_d     = PH_WAIT;
                    end
                end else if (xcvr_done) begin
                    phase_d = PH_ISSUE;
                    case (state)
                        ST_OPC:  state_d = ST_ADDR;
                        ST_ADDR: begin
                            if (idx_q == 2'd0)
`ifdef SPI_RD_SEQ_DUMMY_EN
                                state_d = ST_DUMMY;
`else
                                state_d = after_hdr;
`endif
                        end
`ifdef SPI_RD_SEQ_DUMMY_EN
                        ST_DUMMY: state_d = after_hdr;
`endif
                        ST_DATA: begin
                            obuf_load = 1'b1;
                            obuf_last = last_data;
                            if (last_data)
                                state_d = ST_GAP;
                        end
                        default: state_d = state;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state  <= ST_IDLE;
            phase  <= PH_ISSUE;
            opc_q  <= '0;
            addr_q <= '0;
            rem_q  <= '0;
            idx_q  <= '0;
            gap_q  <= '0;
        end else begin
            state <= state_d;
            phase <= phase_d;
            if (accept) begin
                opc_q  <= cmd_opcode;
                addr_q <= cmd_addr;
                rem_q  <= cmd_len;
                idx_q  <= 2'(ADDR_BYTES - 1);
            end
            if (byte_done && state == ST_ADDR)
                idx_q <= idx_q - 2'd1;
            if (byte_done && state == ST_DATA)
                rem_q <= rem_q - LEN_W'(1);
            if (state == ST_GAP) begin
                if (gap_q != GAP_LAST)
                    gap_q <= gap_q + GAP_W'(1);
            end else begin
                gap_q <= '0;
            end
        end
    end

    spi_rd_obuf u_obuf (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .load       (obuf_load),
        .load_data  (xcvr_rd_data),
        .load_last  (obuf_last),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_last    (rd_last),
        .full       (obuf_full),
        .will_empty (obuf_will_empty)
    );

endmodule
